// File: rtl/atomic_unit_pkg.sv
// Shared definitions for the atomic memory unit: op encodings, FSM states, legality check.
package atomic_unit_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned F5W      = 5;

  localparam logic [F5W-1:0] F5_ADD  = 5'b00000;
  localparam logic [F5W-1:0] F5_SWAP = 5'b00001;
  localparam logic [F5W-1:0] F5_LR   = 5'b00010;
  localparam logic [F5W-1:0] F5_SC   = 5'b00011;
  localparam logic [F5W-1:0] F5_XOR  = 5'b00100;
  localparam logic [F5W-1:0] F5_OR   = 5'b01000;
  localparam logic [F5W-1:0] F5_AND  = 5'b01100;
  localparam logic [F5W-1:0] F5_MIN  = 5'b10000;
  localparam logic [F5W-1:0] F5_MAX  = 5'b10100;
  localparam logic [F5W-1:0] F5_MINU = 5'b11000;
  localparam logic [F5W-1:0] F5_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_SC_CHECK = 3'd2,
    S_WRITE    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  function automatic logic is_legal_op(input logic [F5W-1:0] f);
    case (f)
      F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR, F5_AND,
      F5_MIN, F5_MAX, F5_MINU, F5_MAXU: is_legal_op = 1'b1;
      default:                          is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/atomic_unit_amo_alu.sv
// Read-modify-write arithmetic for AMOs; ties on min/max keep the old memory value.
module amo_alu
  import atomic_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [F5W-1:0]  i_funct5,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  output logic [XLEN-1:0] o_new
);

  logic w_slt;
  logic w_ult;

  always_comb begin
    w_slt = $signed(i_src) < $signed(i_old);
    w_ult = i_src < i_old;
    o_new = i_old;
    case (i_funct5)
      F5_ADD:         o_new = i_old + i_src;
      F5_SWAP, F5_SC: o_new = i_src;
      F5_XOR:         o_new = i_old ^ i_src;
      F5_OR:          o_new = i_old | i_src;
      F5_AND:         o_new = i_old & i_src;
      F5_MIN:         o_new = w_slt ? i_src : i_old;
      F5_MAX:         o_new = (!w_slt && (i_src != i_old)) ? i_src : i_old;
      F5_MINU:        o_new = w_ult ? i_src : i_old;
      F5_MAXU:        o_new = (!w_ult && (i_src != i_old)) ? i_src : i_old;
      default:        o_new = i_old;
    endcase
  end

endmodule

// File: rtl/atomic_unit.sv
// Atomic memory op sequencer (LR/SC/AMO) with one outstanding memory access at a time.
module atomic_unit
  import atomic_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [F5W-1:0]  funct5,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] src,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            lr_valid,
  output logic            sc_valid,
  output logic [XLEN-1:0] lr_addr,
  output logic [XLEN-1:0] sc_addr,
  input  logic            sc_success
);

  state_t          r_state, w_state_nxt;
  logic [F5W-1:0]  r_funct5, w_funct5_nxt;
  logic [XLEN-1:0] r_addr, w_addr_nxt;
  logic [XLEN-1:0] r_src, w_src_nxt;
  logic [XLEN-1:0] r_old, w_old_nxt;
  logic [XLEN-1:0] r_result, w_result_nxt;
  logic            r_fault, w_fault_nxt;
  logic            r_busy, r_done, r_mem_req, r_mem_we, r_sc_valid;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata, w_wdata_nxt;
  logic [XLEN-1:0] w_alu_new;

  amo_alu #(.XLEN(XLEN)) u_alu (
    .i_funct5 (r_funct5),
    .i_old    (mem_rdata),
    .i_src    (r_src),
    .o_new    (w_alu_new)
  );

  // Next-state and datapath; bus outputs are registered from the next state so they
  // are valid in the same cycle the FSM enters READ/WRITE/SC_CHECK.
  always_comb begin
    w_state_nxt  = r_state;
    w_funct5_nxt = r_funct5;
    w_addr_nxt   = r_addr;
    w_src_nxt    = r_src;
    w_old_nxt    = r_old;
    w_result_nxt = r_result;
    w_fault_nxt  = r_fault;
    w_wdata_nxt  = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_funct5_nxt = funct5;
          w_addr_nxt   = addr;
          w_src_nxt    = src;
          if ((addr[1:0] != 2'b00) || !is_legal_op(funct5)) begin
            w_state_nxt  = S_DONE;
            w_fault_nxt  = 1'b1;
            w_result_nxt = '0;
          end else begin
            w_fault_nxt = 1'b0;
            w_state_nxt = (funct5 == F5_SC) ? S_SC_CHECK : S_READ;
          end
        end
      end
      S_READ: begin
        if (mem_ready) begin
          w_old_nxt = mem_rdata;
          if (r_funct5 == F5_LR) begin
            w_state_nxt  = S_DONE;
            w_result_nxt = mem_rdata;
          end else begin
            w_state_nxt = S_WRITE;
            w_wdata_nxt = w_alu_new;
          end
        end
      end
      S_SC_CHECK: begin
        if (sc_success) begin
          w_state_nxt  = S_WRITE;
          w_wdata_nxt  = r_src;
          w_result_nxt = '0;
        end else begin
          w_state_nxt  = S_DONE;
          w_result_nxt = XLEN'(1);
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          w_state_nxt = S_DONE;
          if (r_funct5 != F5_SC) w_result_nxt = r_old;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_funct5    <= '0;
      r_addr      <= '0;
      r_src       <= '0;
      r_old       <= '0;
      r_result    <= '0;
      r_fault     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_sc_valid  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_funct5    <= w_funct5_nxt;
      r_addr      <= w_addr_nxt;
      r_src       <= w_src_nxt;
      r_old       <= w_old_nxt;
      r_result    <= w_result_nxt;
      r_fault     <= w_fault_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_mem_req   <= (w_state_nxt == S_READ) || (w_state_nxt == S_WRITE);
      r_mem_we    <= (w_state_nxt == S_WRITE);
      r_sc_valid  <= (w_state_nxt == S_SC_CHECK);
      r_mem_addr  <= ((w_state_nxt == S_READ) || (w_state_nxt == S_WRITE)) ? w_addr_nxt : '0;
      r_mem_wdata <= (w_state_nxt == S_WRITE) ? w_wdata_nxt : '0;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign fault     = r_fault;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign sc_valid  = r_sc_valid;
  assign sc_addr   = r_addr;
  assign lr_addr   = r_addr;
  // Reservation is registered exactly when the LR read data is accepted.
  assign lr_valid  = (r_state == S_READ) && mem_ready && (r_funct5 == F5_LR);

endmodule

// File: tb/tb_atomic_unit.sv
// Self-checking bench for atomic_unit: memory and reservation models plus a result scoreboard.
module tb_atomic_unit;

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SWAP = 5'b00001, OP_LR = 5'b00010, OP_SC = 5'b00011;
  localparam logic [4:0] OP_XOR = 5'b00100, OP_OR = 5'b01000, OP_AND = 5'b01100;
  localparam logic [4:0] OP_MIN = 5'b10000, OP_MAX = 5'b10100, OP_MINU = 5'b11000, OP_MAXU = 5'b11100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  funct5 = '0;
  logic [31:0] addr = '0, src = '0;
  logic        busy, done, fault, mem_req, mem_we, mem_ready, lr_valid, sc_valid, sc_success;
  logic [31:0] result, mem_addr, mem_wdata, mem_rdata, lr_addr, sc_addr;

  atomic_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct5(funct5), .addr(addr), .src(src),
    .busy(busy), .done(done), .result(result), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .lr_valid(lr_valid), .sc_valid(sc_valid), .lr_addr(lr_addr), .sc_addr(sc_addr),
    .sc_success(sc_success)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] res; logic flt; int lat; bit has_wr; logic [31:0] wa; logic [31:0] wd; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  exp_t exp_q[$];
  wr_t  obs_wr[$];

  // Memory model: word array, configurable wait states, optional always-ready pin.
  logic [31:0] mem [0:255];
  int  wait_cfg = 0;
  int  wcnt;
  bit  force_rdy = 1'b0;
  int  req_cnt = 0;
  int  lr_cnt = 0;
  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = force_rdy | (mem_req && (wcnt == wait_cfg));

  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (!reset && mem_req && mem_we && mem_ready) obs_wr.push_back('{mem_addr, mem_wdata});
    if (!reset && mem_req) req_cnt <= req_cnt + 1;
    if (!reset && lr_valid) lr_cnt <= lr_cnt + 1;
  end

  // Single-entry reservation station
  logic        resv_v;
  logic [31:0] resv_a;
  always @(posedge clk or posedge reset) begin
    if (reset) begin resv_v <= 1'b0; resv_a <= '0; end
    else if (sc_valid) resv_v <= 1'b0;
    else if (lr_valid) begin resv_v <= 1'b1; resv_a <= lr_addr; end
  end
  assign sc_success = sc_valid && resv_v && (resv_a == sc_addr);

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (op)
      OP_ADD:  return a + b;
      OP_SWAP: return b;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_MIN:  return (sb < sa) ? b : a;
      OP_MAX:  return (sb > sa) ? b : a;
      OP_MINU: return (b < a) ? b : a;
      OP_MAXU: return (b > a) ? b : a;
      default: return a;
    endcase
  endfunction

  // Drive one op; lat counts clock edges from the edge that samples start to the one raising done.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] s,
                       output int lat, output logic [31:0] res, output logic flt);
    @(negedge clk);
    funct5 = op; addr = a; src = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    res = result; flt = fault;
    if (done !== 1'b1) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL reset_status busy=%b done=%b fault=%b expected 000", busy, done, fault); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || lr_valid !== 1'b0 || sc_valid !== 1'b0) begin failures++; $display("FAIL reset_strobes req=%b we=%b lr=%b sc=%b expected 0000", mem_req, mem_we, lr_valid, sc_valid); end
    checks++; if ({result, mem_addr, mem_wdata, lr_addr, sc_addr} !== 160'd0) begin failures++; $display("FAIL reset_data result=%h addr=%h wdata=%h lr=%h sc=%h expected 0", result, mem_addr, mem_wdata, lr_addr, sc_addr); end
  endtask

  task automatic test_amo_add();
    int lat, n0; logic [31:0] res; logic flt; exp_t e;
    mem[8'h40] = 32'd5; n0 = obs_wr.size();
    exp_q.push_back('{32'd5, 1'b0, 3, 1'b1, 32'h100, 32'd8});
    issue(OP_ADD, 32'h100, 32'd3, lat, res, flt);
    e = exp_q.pop_front();
    checks++; if (res !== e.res || flt !== e.flt) begin failures++; $display("FAIL add_result got %h/%b expected %h/%b", res, flt, e.res, e.flt); end
    checks++; if (lat != e.lat) begin failures++; $display("FAIL add_latency got %0d expected %0d", lat, e.lat); end
    checks++;
    if (obs_wr.size() - n0 != 1) begin failures++; $display("FAIL add_write count got %0d expected 1", obs_wr.size() - n0); end
    else if (obs_wr[n0].a !== e.wa || obs_wr[n0].d !== e.wd) begin failures++; $display("FAIL add_write got %h@%h expected %h@%h", obs_wr[n0].d, obs_wr[n0].a, e.wd, e.wa); end
  endtask

  task automatic test_lr_sc();
    int lat, n0, l0; logic [31:0] res; logic flt; exp_t e;
    mem[8'h80] = 32'hAA; n0 = obs_wr.size(); l0 = lr_cnt;
    exp_q.push_back('{32'hAA, 1'b0, 2, 1'b0, 32'h0, 32'h0});
    issue(OP_LR, 32'h200, 32'h0, lat, res, flt);
    e = exp_q.pop_front();
    checks++; if (res !== e.res || flt !== e.flt || lat != e.lat) begin failures++; $display("FAIL lr_result got %h/%b lat %0d expected %h/%b lat %0d", res, flt, lat, e.res, e.flt, e.lat); end
    checks++; if (lr_cnt - l0 != 1 || obs_wr.size() != n0) begin failures++; $display("FAIL lr_side lr_pulses=%0d writes=%0d expected 1 and 0", lr_cnt - l0, obs_wr.size() - n0); end
    exp_q.push_back('{32'h0, 1'b0, 3, 1'b1, 32'h200, 32'h55});
    issue(OP_SC, 32'h200, 32'h55, lat, res, flt);
    e = exp_q.pop_front();
    checks++; if (res !== e.res || flt !== e.flt || lat != e.lat) begin failures++; $display("FAIL sc_ok_result got %h/%b lat %0d expected %h/%b lat %0d", res, flt, lat, e.res, e.flt, e.lat); end
    checks++;
    if (obs_wr.size() - n0 != 1) begin failures++; $display("FAIL sc_ok_write count got %0d expected 1", obs_wr.size() - n0); end
    else if (obs_wr[n0].a !== e.wa || obs_wr[n0].d !== e.wd) begin failures++; $display("FAIL sc_ok_write got %h@%h expected %h@%h", obs_wr[n0].d, obs_wr[n0].a, e.wd, e.wa); end
  endtask

  task automatic test_sc_fail();
    int lat, n0, r0; logic [31:0] res; logic flt; exp_t e;
    n0 = obs_wr.size(); r0 = req_cnt;
    force_rdy = 1'b1;
    exp_q.push_back('{32'd1, 1'b0, 2, 1'b0, 32'h0, 32'h0});
    issue(OP_SC, 32'h204, 32'h77, lat, res, flt);
    force_rdy = 1'b0;
    e = exp_q.pop_front();
    checks++; if (res !== e.res || flt !== e.flt || lat != e.lat) begin failures++; $display("FAIL sc_fail_result got %h/%b lat %0d expected %h/%b lat %0d", res, flt, lat, e.res, e.flt, e.lat); end
    checks++; if (obs_wr.size() != n0 || req_cnt != r0) begin failures++; $display("FAIL sc_fail_mem writes=%0d reqs=%0d expected 0 and 0", obs_wr.size() - n0, req_cnt - r0); end
  endtask

  task automatic test_alu_ops();
    logic [4:0] ops [0:9];
    int lat, n0; logic [31:0] res, old, s; logic flt; exp_t e;
    ops = '{OP_MIN, OP_MINU, OP_ADD, OP_XOR, OP_OR, OP_AND, OP_MAX, OP_MAXU, OP_MAX, OP_MINU};
    for (int i = 0; i < 10; i++) begin
      if (i < 2) begin old = 32'hFFFF_FFFF; s = 32'd1; end
      else if (i == 2) begin old = 32'hFFFF_FFFF; s = 32'd2; end
      else begin old = $urandom; s = (i >= 8) ? old : $urandom; end
      mem[8'hC0 + 8'(i)] = old; n0 = obs_wr.size();
      exp_q.push_back('{old, 1'b0, 3, 1'b1, 32'h300 + 32'(i * 4), ref_alu(ops[i], old, s)});
      issue(ops[i], 32'h300 + 32'(i * 4), s, lat, res, flt);
      e = exp_q.pop_front();
      checks++; if (res !== e.res || flt !== e.flt || lat != e.lat) begin failures++; $display("FAIL alu_%0d_result op=%b got %h/%b lat %0d expected %h/%b lat %0d", i, ops[i], res, flt, lat, e.res, e.flt, e.lat); end
      checks++;
      if (obs_wr.size() - n0 != 1) begin failures++; $display("FAIL alu_%0d_write count got %0d expected 1", i, obs_wr.size() - n0); end
      else if (obs_wr[n0].a !== e.wa || obs_wr[n0].d !== e.wd) begin failures++; $display("FAIL alu_%0d_write op=%b got %h@%h expected %h@%h", i, ops[i], obs_wr[n0].d, obs_wr[n0].a, e.wd, e.wa); end
    end
  endtask

  task automatic test_swap_wait();
    int lat, n0; logic [31:0] res, p_a, p_d; logic flt, p_req, p_rdy, p_we; exp_t e;
    wait_cfg = 3; mem[8'hD0] = 32'h1234; mem[8'hC4] = 32'h0; n0 = obs_wr.size();
    exp_q.push_back('{32'h1234, 1'b0, 9, 1'b1, 32'h340, 32'hBEEF});
    @(negedge clk);
    funct5 = OP_SWAP; addr = 32'h340; src = 32'hBEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      p_req = mem_req; p_rdy = mem_ready; p_a = mem_addr; p_we = mem_we; p_d = mem_wdata;
      if (lat == 3) begin start = 1'b1; funct5 = OP_ADD; addr = 32'h310; src = 32'd7; end
      else start = 1'b0;
      @(posedge clk); #1; lat++;
      if (p_req && !p_rdy && mem_req) begin
        checks++;
        if ({mem_addr, mem_we, mem_wdata} !== {p_a, p_we, p_d}) begin failures++; $display("FAIL swap_stable cycle %0d got %h/%b/%h expected %h/%b/%h", lat, mem_addr, mem_we, mem_wdata, p_a, p_we, p_d); end
      end
    end
    start = 1'b0;
    res = result; flt = fault;
    if (done !== 1'b1) lat = -1;
    repeat (3) @(posedge clk); #1;
    wait_cfg = 0;
    e = exp_q.pop_front();
    checks++; if (res !== e.res || flt !== e.flt || lat != e.lat) begin failures++; $display("FAIL swap_result got %h/%b lat %0d expected %h/%b lat %0d", res, flt, lat, e.res, e.flt, e.lat); end
    checks++;
    if (obs_wr.size() - n0 != 1) begin failures++; $display("FAIL swap_write count got %0d expected 1 (start while busy must be ignored)", obs_wr.size() - n0); end
    else if (obs_wr[n0].a !== e.wa || obs_wr[n0].d !== e.wd) begin failures++; $display("FAIL swap_write got %h@%h expected %h@%h", obs_wr[n0].d, obs_wr[n0].a, e.wd, e.wa); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL swap_idle busy=%b expected 0", busy); end
  endtask

  task automatic test_fault();
    logic [4:0] ops [0:1];
    logic [31:0] adrs [0:1];
    int lat, n0, r0; logic [31:0] res; logic flt; exp_t e;
    ops = '{OP_ADD, 5'b00101};
    adrs = '{32'h102, 32'h100};
    for (int i = 0; i < 2; i++) begin
      n0 = obs_wr.size(); r0 = req_cnt;
      exp_q.push_back('{32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0});
      issue(ops[i], adrs[i], 32'h9, lat, res, flt);
      e = exp_q.pop_front();
      checks++; if (res !== e.res || flt !== e.flt || lat != e.lat) begin failures++; $display("FAIL fault_%0d_result got %h/%b lat %0d expected %h/%b lat %0d", i, res, flt, lat, e.res, e.flt, e.lat); end
      checks++; if (req_cnt != r0 || obs_wr.size() != n0) begin failures++; $display("FAIL fault_%0d_mem reqs=%0d writes=%0d expected 0 and 0", i, req_cnt - r0, obs_wr.size() - n0); end
    end
  endtask

  task automatic test_reset_mid();
    int k, n0; bit any_req;
    wait_cfg = 3; mem[8'hC6] = 32'h10; n0 = obs_wr.size();
    @(negedge clk);
    funct5 = OP_ADD; addr = 32'h318; src = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; k = 0;
    while (mem_we !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rstmid_reach_write mem_we=%b expected 1", mem_we); end
    reset = 1'b1; #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_drop req=%b we=%b busy=%b expected 000", mem_req, mem_we, busy); end
    @(negedge clk); reset = 1'b0;
    any_req = 1'b0;
    repeat (10) begin @(posedge clk); #1; any_req |= mem_req; end
    checks++; if (any_req || obs_wr.size() != n0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_after req_seen=%b writes=%0d busy=%b expected 0,0,0", any_req, obs_wr.size() - n0, busy); end
    wait_cfg = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); reset = 1'b0;
    test_amo_add();
    test_lr_sc();
    test_sc_fail();
    test_alu_ops();
    test_swap_wait();
    test_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atomic_unit.md
ATOMIC_UNIT -- requirements
Module: atomic_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32 (from shared config), data/address width.
REQ-002 SHALL have clk  input  1  clock, rising-edge.
REQ-003 SHALL have reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have start  input  1  request new atomic op; accepted only in IDLE.
REQ-005 SHALL have funct5  input  5  op: ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
REQ-006 SHALL have addr  input  XLEN  target address (rs1).
REQ-007 SHALL have src  input  XLEN  operand/store data (rs2).
REQ-008 SHALL have busy  output  1  high in every non-IDLE state.
REQ-009 SHALL have done  output  1  one-cycle completion pulse.
REQ-010 SHALL have result  output  XLEN  rd value, valid while done=1.
REQ-011 SHALL have fault  output  1  misaligned/illegal flag, valid while done=1.
REQ-012 SHALL have mem_req, mem_we  output  1 each  memory request, write enable.
REQ-013 SHALL have mem_addr, mem_wdata  output  XLEN each  memory address, write data.
REQ-014 SHALL have mem_rdata  input  XLEN, mem_ready  input  1  memory response.
REQ-015 SHALL have lr_valid, sc_valid  output  1 each, lr_addr, sc_addr  output  XLEN each  reservation-station drive.
REQ-016 SHALL have sc_success  input  1  combinational reservation-station verdict.

Function
REQ-017 States SHALL be IDLE, READ, SC_CHECK, WRITE, DONE.
REQ-018 In IDLE with start=1 SHALL latch funct5/addr/src; any start while busy SHALL be ignored.
REQ-019 On start, addr[1:0]!=0 or funct5 not in REQ-005 SHALL go to DONE with fault=1, result=0, no memory or reservation activity.
REQ-020 Otherwise: LR/AMO -> READ; SC -> SC_CHECK.
REQ-021 READ: mem_req=1, mem_we=0, mem_addr=latched addr; on mem_ready capture mem_rdata as old; LR -> DONE, AMO -> WRITE.
REQ-022 lr_valid SHALL pulse exactly the cycle READ sees mem_ready for LR, lr_addr=latched addr.
REQ-023 SC_CHECK: sc_valid=1 for exactly one cycle, sc_addr=latched addr; sc_success=1 -> WRITE with result 0; else -> DONE with result 1, no write.
REQ-024 WRITE: mem_req=1, mem_we=1, mem_wdata = src (SC, SWAP) or amo_alu(old, src); on mem_ready -> DONE.
REQ-025 AMO result SHALL be old; LR result SHALL be old.
REQ-026 ALU: ADD modulo 2^XLEN; MIN/MAX signed; MINU/MAXU unsigned; equal operands return old.
REQ-027 mem_addr/mem_we/mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0; mem_ready SHALL be honoured in the same cycle mem_req rises.
REQ-028 mem_ready outside READ/WRITE SHALL be ignored.
REQ-029 DONE: done=1 one cycle, then IDLE; start in DONE ignored.
REQ-030 Zero-wait latency from start edge to done: LR 2, SC-fail 2, SC-success 3, AMO 3 cycles; each memory wait cycle adds one.

Reset
REQ-031 Reset SHALL force IDLE immediately; busy, done, fault, mem_req, mem_we, lr_valid, sc_valid = 0; result, mem_addr, mem_wdata, lr_addr, sc_addr = 0.
REQ-032 Reset mid-operation SHALL abandon the op with no further memory write issued after reset deasserts.

Structure
REQ-033 funct5 encodings and state encodings SHALL live in shared header atomic_defs.vh, included alongside rv_config.vh.
REQ-034 Combinational sub-module amo_alu(funct5, old, src -> new) SHALL hold REQ-026 arithmetic.

Verification
REQ-035 AMOADD addr=0x100, mem=5, src=3, zero-wait -> write 8 to 0x100, result=5, done 3 cycles after start.
REQ-036 LR 0x200 (mem 0xAA) then SC 0x200 src=0x55 -> lr_valid pulse, result 0xAA; SC write 0x55, result 0.
REQ-037 SC 0x204 without LR (sc_success=0) -> no mem_we, result=1, done 2 cycles after start.
REQ-038 AMOMIN old=0xFFFFFFFF, src=1 -> write 0xFFFFFFFF; AMOMINU same -> write 1.
REQ-039 AMOSWAP with mem_ready delayed 3 cycles per access -> signals stable during wait, done at cycle 9; start during busy ignored.
REQ-040 addr=0x102 -> fault=1, no mem_req; reset asserted in WRITE -> mem_req drops same cycle, IDLE.
